pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control sequencer that drives the program counter's flagPC/newAddress inputs.
- Accepts one decoded control-flow operation per cycle from the instruction decoder.
- Resolves conditional branches against the zero flag and keeps a hardware return-address stack for CALL/RET.
- Manages DELAY-based waits and HALT/resume, and sits between the decoder and the program counter.

Parameters:
- ADDR_WIDTH, 12: width of the address, target, newAddress and stack entries.
- STACK_DEPTH, 4: return-stack entries; must be a power of 2, minimum 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserted low clears all state immediately.
- instr_valid  input  1  decoded operation present this cycle.
- op  input  3  operation: 0 SEQ, 1 JMP, 2 BZ, 3 BNZ, 4 CALL, 5 RET, 6 WAIT, 7 HALT.
- target  input  ADDR_WIDTH  jump/branch/call destination.
- zero  input  1  ALU zero flag, sampled with instr_valid.
- address  input  ADDR_WIDTH  current program counter value.
- resume  input  1  leave HALT.
- flagPC  output  3  PC command: 0 hold, 1 INCREASE, 2 JUMP, 3 DELAY.
- newAddress  output  ADDR_WIDTH  jump address to the PC.
- ready  output  1  high when in RUN; decoder presents ops only while ready.
- halted  output  1  high in HALT.
- fault  output  1  sticky stack error.
- stack_level  output  $clog2(STACK_DEPTH)+1  entries currently on the stack.

Behaviour:
- Reset (reset=0): state=RUN, flagPC=0, newAddress=0, ready=1, halted=0, fault=0, stack_level=0, stack pointer=0, wait capture=0.
- All outputs are registered. A command accepted at edge N appears on flagPC/newAddress after edge N and lasts exactly one cycle, except DELAY in WAIT.
- RUN, instr_valid=0: flagPC=0.
- RUN, instr_valid=1, decoded per op:
  - SEQ: flagPC=1.
  - JMP: flagPC=2, newAddress=target.
  - BZ: zero=1 -> flagPC=2, newAddress=target; else flagPC=1.
  - BNZ: same as BZ with the zero condition inverted.
  - CALL: push address+1 (mod 2^ADDR_WIDTH), flagPC=2, newAddress=target.
  - CALL with stack full (level=STACK_DEPTH): no push, flagPC=0, fault=1, state=FAULT.
  - RET: pop; flagPC=2, newAddress=popped entry.
  - RET with stack empty: flagPC=0, fault=1, state=FAULT.
  - WAIT: capture address into wait_addr, flagPC=3, state=WAIT.
  - HALT: flagPC=0, state=HALT.
- WAIT: flagPC held at 3 every cycle while address==wait_addr. When address!=wait_addr, the next cycle gives flagPC=0 and state=RUN. ready=0.
- HALT: flagPC=0, halted=1, ready=0. resume=1 -> next cycle flagPC=1, state=RUN (continues past the HALT instruction).
- FAULT: flagPC=0, ready=0. Exited only by reset; resume is ignored.
- instr_valid outside RUN is ignored; no stack change. resume outside HALT is ignored.
- Stack is LIFO with a single pointer; push and pop never occur in the same cycle.
- newAddress holds its last value when flagPC != 2.
- Reset asserted mid-WAIT or mid-HALT: immediate return to reset values; stack contents are discarded.

Optional Feature:
- Macro PCSEQ_STACK_WRAP_EN.
- Defined: the stack is circular.
  - CALL when full overwrites the oldest entry; stack_level stays at STACK_DEPTH; no fault.
  - RET when empty still faults.
- Undefined: overflow faults as specified in Behaviour.

Test Plan:
- Reset release, then SEQ,SEQ -> flagPC pulses 1,1; ready=1; fault=0; newAddress=0.
- zero=1: BZ target=0x0A0 -> flagPC=2, newAddress=0x0A0; zero=1: BNZ target=0x0B0 -> flagPC=1.
- address=0x010, CALL target=0x200 -> flagPC=2, newAddress=0x200, stack_level=1; later RET -> flagPC=2, newAddress=0x011, stack_level=0.
- Five nested CALLs with STACK_DEPTH=4:
  - Macro off: 5th gives fault=1, ready=0, flagPC=0, held until reset.
  - Macro on: no fault; four RETs return the last four pushes in reverse order; 5th RET faults.
- address=0x030, WAIT -> flagPC=3 held for 20 cycles; bench changes address to 0x031 -> next cycle flagPC=0, ready=1.
- HALT -> halted=1, instr_valid ignored for 10 cycles; resume=1 -> flagPC=1, halted=0. Reset pulsed low mid-HALT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: flagPC/newAddress sequencer with return stack; PCSEQ_STACK_WRAP_EN makes the stack circular
module pc_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           instr_valid,
  input  logic [2:0]                     op,
  input  logic [ADDR_WIDTH-1:0]          target,
  input  logic                           zero,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic                           resume,
  output logic [2:0]                     flagPC,
  output logic [ADDR_WIDTH-1:0]          newAddress,
  output logic                           ready,
  output logic                           halted,
  output logic                           fault,
  output logic [$clog2(STACK_DEPTH):0]   stack_level
);
  localparam int PW = $clog2(STACK_DEPTH);
  localparam int LW = PW + 1;
`ifdef PCSEQ_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [2:0] OP_SEQ = 3'd0, OP_JMP = 3'd1, OP_BZ = 3'd2, OP_BNZ = 3'd3,
                         OP_CALL = 3'd4, OP_RET = 3'd5, OP_WAIT = 3'd6, OP_HALT = 3'd7;
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT, S_FAULT} state_t;
  state_t                state, state_n;
  logic [2:0]            flag_n;
  logic [ADDR_WIDTH-1:0] addr_n, wait_addr, wait_n;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
  logic [PW-1:0]         ptr, ptr_n;
  logic [LW-1:0]         lvl, lvl_n;
  logic                  fault_n, push, full, empty;
  assign full        = lvl == LW'(STACK_DEPTH);
  assign empty       = lvl == '0;
  assign ready       = state == S_RUN;
  assign halted      = state == S_HALT;
  assign stack_level = lvl;
  always_comb begin
    state_n = state;
    flag_n  = 3'd0;
    addr_n  = newAddress;
    wait_n  = wait_addr;
    ptr_n   = ptr;
    lvl_n   = lvl;
    fault_n = fault;
    push    = 1'b0;
    case (state)
      S_RUN: if (instr_valid) begin
        case (op)
          OP_SEQ: flag_n = 3'd1;
          OP_JMP: begin
            flag_n = 3'd2;
            addr_n = target;
          end
          OP_BZ, OP_BNZ: begin
            flag_n = (zero == (op == OP_BZ)) ? 3'd2 : 3'd1;
            addr_n = (zero == (op == OP_BZ)) ? target : newAddress;
          end
          OP_CALL: if (full && !WRAP) begin
            fault_n = 1'b1;
            state_n = S_FAULT;
          end else begin
            push   = 1'b1;
            flag_n = 3'd2;
            addr_n = target;
            ptr_n  = ptr + 1'b1;
            lvl_n  = full ? lvl : lvl + 1'b1;
          end
          OP_RET: if (empty) begin
            fault_n = 1'b1;
            state_n = S_FAULT;
          end else begin
            flag_n = 3'd2;
            addr_n = stack[ptr - 1'b1];
            ptr_n  = ptr - 1'b1;
            lvl_n  = lvl - 1'b1;
          end
          OP_WAIT: begin
            wait_n  = address;
            flag_n  = 3'd3;
            state_n = S_WAIT;
          end
          default: state_n = S_HALT;
        endcase
      end
      S_WAIT: begin
        flag_n  = (address == wait_addr) ? 3'd3 : 3'd0;
        state_n = (address == wait_addr) ? S_WAIT : S_RUN;
      end
      S_HALT: begin
        flag_n  = resume ? 3'd1 : 3'd0;
        state_n = resume ? S_RUN : S_HALT;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state      <= S_RUN;
      flagPC     <= '0;
      newAddress <= '0;
      wait_addr  <= '0;
      ptr        <= '0;
      lvl        <= '0;
      fault      <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      state      <= state_n;
      flagPC     <= flag_n;
      newAddress <= addr_n;
      wait_addr  <= wait_n;
      ptr        <= ptr_n;
      lvl        <= lvl_n;
      fault      <= fault_n;
      if (push) stack[ptr] <= address + 1'b1;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table, directed corner sequences and a randomized run against a queue-based model
module tb_pc_sequencer;
  localparam int AW = 12;
  localparam int D  = 4;
`ifdef PCSEQ_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic          clock = 1'b0, reset = 1'b0, instr_valid = 1'b0, zero = 1'b0, resume = 1'b0;
  logic [2:0]    op = '0;
  logic [AW-1:0] target = '0, address = '0;
  logic [2:0]    flagPC;
  logic [AW-1:0] newAddress;
  logic          ready, halted, fault;
  logic [2:0]    stack_level;
  int tests = 0, failed = 0;

  pc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .op(op), .target(target),
    .zero(zero), .address(address), .resume(resume), .flagPC(flagPC), .newAddress(newAddress),
    .ready(ready), .halted(halted), .fault(fault), .stack_level(stack_level));

  always #5 clock = ~clock;

  typedef struct {
    logic          v;
    logic [2:0]    op;
    logic          z;
    logic [AW-1:0] tgt;
    logic [AW-1:0] adr;
    logic [2:0]    f;
    logic [AW-1:0] na;
    logic [2:0]    lvl;
  } vec_t;
  vec_t vt[10];

  // reference model: mode 0 run, 1 wait, 2 halt, 3 fault
  int            m_mode;
  logic [AW-1:0] m_q[$];
  logic [AW-1:0] m_wa, m_na;
  logic [2:0]    m_flag;
  logic          m_fault;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic z,
                       input logic [AW-1:0] t, input logic [AW-1:0] a);
    instr_valid = v; op = o; zero = z; target = t; address = a;
  endtask

  task automatic model_reset();
    m_mode = 0; m_q.delete(); m_wa = '0; m_na = '0; m_flag = '0; m_fault = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic model_step();
    logic [AW-1:0] ra;
    m_flag = 3'd0;
    case (m_mode)
      0: if (instr_valid) begin
        case (op)
          3'd0: m_flag = 3'd1;
          3'd1: begin m_flag = 3'd2; m_na = target; end
          3'd2, 3'd3: if (zero == (op == 3'd2)) begin m_flag = 3'd2; m_na = target; end
                      else m_flag = 3'd1;
          3'd4: if (m_q.size() == D && !WRAP) begin m_fault = 1'b1; m_mode = 3; end
                else begin
                  ra = address + 12'd1;
                  m_q.push_back(ra);
                  if (m_q.size() > D) void'(m_q.pop_front());
                  m_flag = 3'd2; m_na = target;
                end
          3'd5: if (m_q.size() == 0) begin m_fault = 1'b1; m_mode = 3; end
                else begin m_na = m_q.pop_back(); m_flag = 3'd2; end
          3'd6: begin m_wa = address; m_flag = 3'd3; m_mode = 1; end
          default: m_mode = 2;
        endcase
      end
      1: if (address == m_wa) m_flag = 3'd3; else m_mode = 0;
      2: if (resume) begin m_flag = 3'd1; m_mode = 0; end
      default: ;
    endcase
  endtask

  task automatic chk_model();
    chk("rnd_flag", flagPC, m_flag);
    chk("rnd_na", newAddress, m_na);
    chk("rnd_ready", ready, m_mode == 0);
    chk("rnd_halted", halted, m_mode == 2);
    chk("rnd_fault", fault, m_fault);
    chk("rnd_level", stack_level, m_q.size());
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_flag"}, flagPC, 0);
    chk({n, "_na"}, newAddress, 0);
    chk({n, "_ready"}, ready, 1);
    chk({n, "_halted"}, halted, 0);
    chk({n, "_fault"}, fault, 0);
    chk({n, "_level"}, stack_level, 0);
  endtask

  initial begin
    vt[0] = '{1'b1, 3'd0, 1'b0, 12'h000, 12'h000, 3'd1, 12'h000, 3'd0};
    vt[1] = '{1'b1, 3'd0, 1'b0, 12'h000, 12'h001, 3'd1, 12'h000, 3'd0};
    vt[2] = '{1'b1, 3'd2, 1'b1, 12'h0A0, 12'h002, 3'd2, 12'h0A0, 3'd0};
    vt[3] = '{1'b1, 3'd3, 1'b1, 12'h0B0, 12'h0A0, 3'd1, 12'h0A0, 3'd0};
    vt[4] = '{1'b1, 3'd4, 1'b0, 12'h200, 12'h010, 3'd2, 12'h200, 3'd1};
    vt[5] = '{1'b0, 3'd1, 1'b0, 12'h777, 12'h200, 3'd0, 12'h200, 3'd1};
    vt[6] = '{1'b1, 3'd2, 1'b0, 12'h300, 12'h200, 3'd1, 12'h200, 3'd1};
    vt[7] = '{1'b1, 3'd3, 1'b0, 12'h0C0, 12'h201, 3'd2, 12'h0C0, 3'd1};
    vt[8] = '{1'b1, 3'd1, 1'b0, 12'h123, 12'h0C0, 3'd2, 12'h123, 3'd1};
    vt[9] = '{1'b1, 3'd5, 1'b0, 12'h000, 12'h123, 3'd2, 12'h011, 3'd0};
    model_reset();
    #12;
    chk_reset_vals("reset");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].v, vt[i].op, vt[i].z, vt[i].tgt, vt[i].adr);
      step();
      chk($sformatf("vec%0d_flag", i), flagPC, vt[i].f);
      chk($sformatf("vec%0d_na", i), newAddress, vt[i].na);
      chk($sformatf("vec%0d_level", i), stack_level, vt[i].lvl);
      chk($sformatf("vec%0d_ready", i), ready, 1);
      chk($sformatf("vec%0d_fault", i), fault, 0);
    end
    // WAIT holds DELAY until the PC moves
    drive(1'b1, 3'd6, 1'b0, 12'h000, 12'h030);
    step();
    chk("wait_enter_flag", flagPC, 3);
    chk("wait_enter_ready", ready, 0);
    instr_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("wait_hold_flag", flagPC, 3);
    end
    address = 12'h031;
    step();
    chk("wait_exit_flag", flagPC, 0);
    chk("wait_exit_ready", ready, 1);
    // HALT ignores ops until resume
    drive(1'b1, 3'd7, 1'b0, 12'h000, 12'h031);
    step();
    chk("halt_flag", flagPC, 0);
    chk("halt_halted", halted, 1);
    chk("halt_ready", ready, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd1, 1'b0, 12'h555, 12'h031);
      step();
      chk("halt_ign_flag", flagPC, 0);
      chk("halt_ign_halted", halted, 1);
    end
    instr_valid = 1'b0;
    resume = 1'b1;
    step();
    chk("resume_flag", flagPC, 1);
    chk("resume_halted", halted, 0);
    resume = 1'b0;
    step();
    chk("resume_pulse", flagPC, 0);
    drive(1'b1, 3'd7, 1'b0, 12'h000, 12'h032);
    step();
    instr_valid = 1'b0;
    step();
    reset = 1'b0;
    #2;
    chk_reset_vals("async_reset");
    reset = 1'b1;
    model_reset();
    // five nested CALLs
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd4, 1'b0, 12'h400 + 12'(i), 12'h100 + 12'(i));
      step();
      if (i < 4) begin
        chk("call_flag", flagPC, 2);
        chk("call_level", stack_level, i + 1);
      end
    end
    if (!WRAP) begin
      chk("ovf_flag", flagPC, 0);
      chk("ovf_fault", fault, 1);
      chk("ovf_ready", ready, 0);
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, 3'd0, 1'b0, 12'h000, 12'h000);
        resume = 1'b1;
        step();
        chk("ovf_hold_flag", flagPC, 0);
        chk("ovf_hold_fault", fault, 1);
        chk("ovf_hold_ready", ready, 0);
      end
      resume = 1'b0;
    end else begin
      chk("wrap_flag", flagPC, 2);
      chk("wrap_fault", fault, 0);
      chk("wrap_level", stack_level, 4);
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 3'd5, 1'b0, 12'h000, 12'h000);
        step();
        chk("wrap_ret_flag", flagPC, 2);
        chk("wrap_ret_na", newAddress, 12'h105 - 12'(i));
      end
      step();
      chk("wrap_empty_flag", flagPC, 0);
      chk("wrap_empty_fault", fault, 1);
    end
    do_reset();
    chk_reset_vals("post_fault_reset");
    // randomized run against the model
    for (int c = 0; c < 600; c++) begin
      instr_valid = $urandom_range(0, 3) != 0;
      op = 3'($urandom_range(0, 7));
      zero = 1'($urandom);
      target = 12'($urandom);
      resume = $urandom_range(0, 3) == 0;
      if (m_mode != 1 || $urandom_range(0, 3) == 0) address = 12'($urandom);
      model_step();
      step();
      chk_model();
      if (m_mode == 3 && $urandom_range(0, 3) == 0) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
